// File: rtl/ra_stack_if.sv
// Control-side bundle for the return-address stack: call/return strobes in,
// top-of-stack, popped address and occupancy/error status out.
interface ra_stack_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_addr;
    logic             clr_err;
    logic [WIDTH-1:0] top_out;
    logic [WIDTH-1:0] pop_addr;
    logic             pop_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_addr, clr_err,
        input  top_out, pop_addr, pop_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, clr_err,
        output top_out, pop_addr, pop_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ra_stack.sv
// Hardware return-address stack: calls push the return address, returns pop it
// into a registered restore value (pop_addr/pop_valid) for the PC write mux.
module ra_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic      clk,
    input  logic      rst,
    ra_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pop_addr;
    logic             pop_valid;
    logic             overflow;
    logic             underflow;

    logic             empty;
    logic             full;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             replace;
    logic             push_only;
    logic             pop_only;
    logic             pop_ok;
    logic             wr_en;
    logic             ovf_evt;
    logic             udf_evt;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Low bits of count minus one still address the top entry when count == DEPTH.
    assign top_idx = count[AW-1:0] - AW'(1);

    // Push+pop on an empty stack degrades to a plain push (with underflow flagged).
    assign replace   = bus.push && bus.pop && !empty;
    assign push_only = bus.push && (!bus.pop || empty);
    assign pop_only  = bus.pop && !bus.push && !empty;
    assign pop_ok    = bus.pop && !empty;

    assign wr_en   = replace || (push_only && !full);
    assign wr_idx  = replace ? top_idx : count[AW-1:0];
    assign ovf_evt = push_only && full;
    assign udf_evt = bus.pop && empty;

    // Storage has no reset: entries above the pointer are never observed.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= bus.push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push_only && !full) begin
            count <= count + CW'(1);
        end else if (pop_only) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_addr  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_addr <= mem[top_idx];
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    assign bus.top_out   = empty ? '0 : mem[top_idx];
    assign bus.pop_addr  = pop_addr;
    assign bus.pop_valid = pop_valid;
    assign bus.count     = count;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule
